// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the eight-requester round-robin arbiter.
package arb_pkg;

   localparam int unsigned N_REQ = 8;
   localparam int unsigned IDX_W = 3;

   typedef enum logic {
      ARB_IDLE,
      ARB_GRANT
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority first-set finder: scans req starting at ptr and wrapping modulo N_REQ.
module rr_pick
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         // Addition wraps naturally in IDX_W bits, giving the modulo-8 scan order.
         cand = ptr + IDX_W'(k);
         if (!any && req[cand]) begin
            idx = cand;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_eight.sv
// Eight-requester round-robin arbiter with grant hold, done/withdraw release and
// optional forced release after HOLD_MAX cycles (enabled by ARB_TIMEOUT_EN).
module rr_arbiter_eight
   import arb_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 15
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [2:0] grant_idx,
   output logic       grant_valid,
   output logic       timeout
);

   arb_state_t       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic             rel;
   logic             expire;

   rr_pick u_pick (
      .req (req),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign rel = done | ~req[idx_q];

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       timeout_q, timeout_d;

   assign expire  = (cnt_q == HOLD_LAST);
   assign timeout = timeout_q;
`else
   assign expire  = 1'b0;
   // Constant 0 over the legal HOLD_MAX range; keeps the parameter referenced.
   assign timeout = (HOLD_MAX == 0);
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               state_d = ARB_GRANT;
               idx_d   = pick_idx;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ARB_GRANT: begin
            if (rel || expire) begin
               state_d = ARB_IDLE;
               ptr_d   = idx_q + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
               timeout_d = ~rel;
`endif
            end
`ifdef ARB_TIMEOUT_EN
            else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         idx_q   <= '0;
         ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign grant_idx   = idx_q;
   assign grant_valid = (state_q == ARB_GRANT);

endmodule

// File: tb/tb_rr_arbiter_eight.sv
// Scoreboard bench for rr_arbiter_eight: a behavioural model pushes expected outputs
// each edge, a negedge monitor pops and compares; directed phases plus random traffic.
module tb_rr_arbiter_eight;

   localparam int HM = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   rr_arbiter_eight #(.HOLD_MAX(HM)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit v;
      int idx;
      bit to;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: who holds the bus, who was last released, how long held.
   bit m_busy = 1'b0;
   int m_idx  = 0;
   int m_ptr  = 0;
   int m_held = 0;
   bit m_to   = 1'b0;

   always @(posedge clk) begin
      bit found;
      m_to = 1'b0;
      if (rst) begin
         m_busy = 1'b0;
         m_idx  = 0;
         m_ptr  = 0;
         m_held = 0;
      end else if (!m_busy) begin
         found = 1'b0;
         for (int k = 0; k < 8; k++) begin
            if (!found && req[(m_ptr + k) % 8]) begin
               found  = 1'b1;
               m_idx  = (m_ptr + k) % 8;
               m_busy = 1'b1;
               m_held = 0;
            end
         end
      end else begin
         m_held = m_held + 1;
         if (done || !req[m_idx]) begin
            m_busy = 1'b0;
            m_ptr  = (m_idx + 1) % 8;
         end else if (TO_EN && m_held == HM) begin
            m_busy = 1'b0;
            m_ptr  = (m_idx + 1) % 8;
            m_to   = 1'b1;
         end
      end
      q.push_back('{v: m_busy, idx: m_idx, to: m_to});
   end

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         n_checks++;
         if (grant_valid !== e.v || timeout !== e.to || int'(grant_idx) != e.idx) begin
            n_fail++;
            $display("FAIL outputs t=%0t got valid=%b idx=%0d timeout=%b want valid=%b idx=%0d timeout=%b",
                     $time, grant_valid, grant_idx, timeout, e.v, e.idx, e.to);
         end
      end
   end

   // Log of grant indices observed at the start of each DUT grant episode.
   int seen[$];
   bit prev_valid = 1'b0;
   int exp_list[$];

   always @(negedge clk) begin
      if (grant_valid && !prev_valid) seen.push_back(int'(grant_idx));
      prev_valid = grant_valid;
   end

   task automatic check_seen(input string name);
      n_checks++;
      if (seen.size() < exp_list.size()) begin
         n_fail++;
         $display("FAIL %s got %0d grants want at least %0d", name, seen.size(), exp_list.size());
      end else begin
         for (int i = 0; i < exp_list.size(); i++) begin
            if (seen[i] != exp_list[i]) begin
               n_fail++;
               $display("FAIL %s grant #%0d got idx=%0d want idx=%0d", name, i, seen[i], exp_list[i]);
               break;
            end
         end
      end
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst  = 1'b1;
      done = 1'b0;
      repeat (cycles) @(negedge clk);
      rst  = 1'b0;
      seen.delete();
   endtask

   initial begin
      int hc;
      rst  = 1'b1;
      req  = 8'h00;
      done = 1'b0;

      // Idle after reset.
      do_reset(2);
      repeat (5) @(negedge clk);

      // Two requesters alternate with immediate done.
      do_reset(1);
      req = 8'b1000_0001;
      repeat (14) begin
         @(negedge clk);
         done = grant_valid;
      end
      done = 1'b0;
      exp_list = '{0, 7, 0, 7};
      check_seen("alt_0_7");

      // All requesting, done two cycles into each grant: full rotation with wrap.
      do_reset(1);
      req = 8'hFF;
      hc  = 0;
      repeat (40) begin
         @(negedge clk);
         hc   = grant_valid ? hc + 1 : 0;
         done = (hc == 2);
      end
      done = 1'b0;
      exp_list = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
      check_seen("rotate_wrap");

      // Withdrawal releases the grant; pointer moves past the withdrawn holder.
      do_reset(1);
      req = 8'b0001_0000;
      repeat (3) @(negedge clk);
      req = 8'b0000_0100;
      repeat (4) @(negedge clk);
      exp_list = '{4, 2};
      check_seen("withdraw");

      // Reset mid-grant restores the pointer to 0.
      do_reset(1);
      req = 8'b0010_0000;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      req = 8'b0010_0001;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      exp_list = '{5, 0};
      check_seen("reset_mid_grant");

      // Single requester never releasing (forced release when timeout is built).
      do_reset(1);
      req = 8'b0000_1000;
      repeat (12) @(negedge clk);

      // Done on the last allowed hold cycle takes precedence over timeout.
      do_reset(1);
      hc = 0;
      repeat (12) begin
         @(negedge clk);
         hc   = grant_valid ? hc + 1 : 0;
         done = (hc == HM);
      end
      done = 1'b0;

      // Random traffic.
      do_reset(1);
      repeat (800) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
         done = ($urandom_range(0, 3) == 0);
         rst  = ($urandom_range(0, 99) == 0);
      end
      rst  = 1'b0;
      done = 1'b0;
      req  = 8'h00;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
